// File: rtl/calc_sequencer_if.sv
// Keypad / datapath bundle for calc_sequencer: key strobes and datapath result in,
// operand digits, operation select and status out.
interface calc_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] result_in;
    logic        neg_in;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [3:0]  dig4;
    logic [4:0]  operation;
    logic [13:0] result_q;
    logic        neg_q;
    logic        busy;
    logic        done;
    logic        error;
    logic        show_result;

    modport master (
        output key_valid, key_code, result_in, neg_in,
        input  dig1, dig2, dig3, dig4, operation, result_q, neg_q,
               busy, done, error, show_result
    );

    modport slave (
        input  key_valid, key_code, result_in, neg_in,
        output dig1, dig2, dig3, dig4, operation, result_q, neg_q,
               busy, done, error, show_result
    );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the two-operand BCD arithmetic datapath: builds operands
// from key events, selects the operation, waits the datapath latency and captures the result.
module calc_sequencer #(
    parameter int unsigned EXEC_CYCLES = 3
) (
    input  logic           clk,
    input  logic           reset,
    calc_sequencer_if.slave bus
);

    localparam logic [3:0] EXEC_LOAD   = 4'(EXEC_CYCLES - 1);
    localparam logic [4:0] OP_SHOW_OPS = 5'b10000;
    localparam logic [3:0] KEY_EQUAL   = 4'd14;
    localparam logic [3:0] KEY_CLEAR   = 4'd15;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    function automatic logic [3:0] op_onehot(input logic [3:0] code);
        logic [3:0] sel;
        case (code)
            4'd10:   sel = 4'b0001;
            4'd11:   sel = 4'b0010;
            4'd12:   sel = 4'b0100;
            4'd13:   sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  a_tens_q, a_tens_d;
    logic [3:0]  a_units_q, a_units_d;
    logic [3:0]  b_tens_q, b_tens_d;
    logic [3:0]  b_units_q, b_units_d;
    logic [1:0]  a_cnt_q, a_cnt_d;
    logic [1:0]  b_cnt_q, b_cnt_d;
    logic [3:0]  op_sel_q, op_sel_d;
    logic [3:0]  exec_cnt_q, exec_cnt_d;
    logic [13:0] res_q, res_d;
    logic        sign_q, sign_d;
    logic [4:0]  operation_q, operation_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        show_q, show_d;

    logic        key_digit_s;
    logic        key_oper_s;
    logic        key_equal_s;
    logic        key_clear_s;
    logic        b_is_zero_s;

    assign key_digit_s = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_oper_s  = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    assign key_equal_s = bus.key_valid && (bus.key_code == KEY_EQUAL);
    assign key_clear_s = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign b_is_zero_s = (b_tens_q == 4'd0) && (b_units_q == 4'd0);

    // Next-state logic: clear outranks every state-specific key action.
    always_comb begin
        state_d    = state_q;
        a_tens_d   = a_tens_q;
        a_units_d  = a_units_q;
        b_tens_d   = b_tens_q;
        b_units_d  = b_units_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        op_sel_d   = op_sel_q;
        exec_cnt_d = exec_cnt_q;
        res_d      = res_q;
        sign_d     = sign_q;
        done_d     = 1'b0;

        if (key_clear_s) begin
            a_tens_d   = 4'd0;
            a_units_d  = 4'd0;
            b_tens_d   = 4'd0;
            b_units_d  = 4'd0;
            a_cnt_d    = 2'd0;
            b_cnt_d    = 2'd0;
            op_sel_d   = 4'b0000;
            exec_cnt_d = 4'd0;
            res_d      = 14'd0;
            sign_d     = 1'b0;
            state_d    = ST_ENTER_A;
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (key_digit_s) begin
                        if (a_cnt_q < 2'd2) begin
                            a_tens_d  = a_units_q;
                            a_units_d = bus.key_code;
                            a_cnt_d   = a_cnt_q + 2'd1;
                        end else begin
                            a_cnt_d = a_cnt_q;
                        end
                    end else if (key_oper_s) begin
                        op_sel_d = op_onehot(bus.key_code);
                        state_d  = ST_ENTER_B;
                    end else begin
                        state_d = ST_ENTER_A;
                    end
                end
                ST_ENTER_B: begin
                    if (key_digit_s) begin
                        if (b_cnt_q < 2'd2) begin
                            b_tens_d  = b_units_q;
                            b_units_d = bus.key_code;
                            b_cnt_d   = b_cnt_q + 2'd1;
                        end else begin
                            b_cnt_d = b_cnt_q;
                        end
                    end else if (key_oper_s) begin
                        // The operator may only be changed before B has any digit.
                        if (b_cnt_q == 2'd0) begin
                            op_sel_d = op_onehot(bus.key_code);
                        end else begin
                            op_sel_d = op_sel_q;
                        end
                    end else if (key_equal_s) begin
                        if (op_sel_q[3] && b_is_zero_s) begin
                            state_d = ST_ERR;
                        end else begin
                            exec_cnt_d = EXEC_LOAD;
                            state_d    = ST_EXEC;
                        end
                    end else begin
                        state_d = ST_ENTER_B;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt_q == 4'd0) begin
                        res_d   = bus.result_in;
                        sign_d  = bus.neg_in;
                        done_d  = 1'b1;
                        state_d = ST_SHOW;
                    end else begin
                        exec_cnt_d = exec_cnt_q - 4'd1;
                    end
                end
                ST_SHOW: begin
                    // A digit after a result starts a fresh calculation with it as A units.
                    if (key_digit_s) begin
                        a_tens_d  = 4'd0;
                        a_units_d = bus.key_code;
                        a_cnt_d   = 2'd1;
                        b_tens_d  = 4'd0;
                        b_units_d = 4'd0;
                        b_cnt_d   = 2'd0;
                        state_d   = ST_ENTER_A;
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_ENTER_A;
                end
            endcase
        end
    end

    // Output flags are derived from the next state so they register alongside it.
    always_comb begin
        operation_d = OP_SHOW_OPS;
        if ((state_d == ST_EXEC) || (state_d == ST_SHOW)) begin
            operation_d = {1'b0, op_sel_d};
        end else begin
            operation_d = OP_SHOW_OPS;
        end
        busy_d  = (state_d == ST_EXEC);
        error_d = (state_d == ST_ERR);
        show_d  = (state_d == ST_SHOW);
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ENTER_A;
            a_tens_q    <= 4'd0;
            a_units_q   <= 4'd0;
            b_tens_q    <= 4'd0;
            b_units_q   <= 4'd0;
            a_cnt_q     <= 2'd0;
            b_cnt_q     <= 2'd0;
            op_sel_q    <= 4'b0000;
            exec_cnt_q  <= 4'd0;
            res_q       <= 14'd0;
            sign_q      <= 1'b0;
            operation_q <= OP_SHOW_OPS;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            show_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_tens_q    <= a_tens_d;
            a_units_q   <= a_units_d;
            b_tens_q    <= b_tens_d;
            b_units_q   <= b_units_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            op_sel_q    <= op_sel_d;
            exec_cnt_q  <= exec_cnt_d;
            res_q       <= res_d;
            sign_q      <= sign_d;
            operation_q <= operation_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            show_q      <= show_d;
        end
    end

    assign bus.dig1        = a_tens_q;
    assign bus.dig2        = a_units_q;
    assign bus.dig3        = b_tens_q;
    assign bus.dig4        = b_units_q;
    assign bus.operation   = operation_q;
    assign bus.result_q    = res_q;
    assign bus.neg_q       = sign_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.show_result = show_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed keypad scenarios plus a randomized run against
// an arithmetic-level reference model, with a one-register datapath stand-in.
module tb_calc_sequencer;

    localparam int EXEC = 3;
    localparam int P_A = 0, P_B = 1, P_EXEC = 2, P_SHOW = 3, P_ERR = 4;
    localparam logic [39:0] RST_OUTS = {16'h0000, 5'b10000, 14'd0, 1'b0, 4'b0000};

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    calc_sequencer_if bus();
    calc_sequencer #(.EXEC_CYCLES(EXEC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Signed result of the selected operation as {neg, magnitude}.
    function automatic logic [14:0] dp_eval(input int a, input int b, input logic [4:0] op);
        int r;
        case (op)
            5'b00001: r = a + b;
            5'b00010: r = a - b;
            5'b00100: r = a * b;
            5'b01000: r = (b == 0) ? 0 : a / b;
            default:  r = 9999;
        endcase
        if (r < 0) return {1'b1, 14'(-r)};
        else       return {1'b0, 14'(r)};
    endfunction

    // Datapath stand-in: one register stage after digits/operation settle.
    always @(posedge clk)
        {bus.neg_in, bus.result_in} <= dp_eval(int'(bus.dig1) * 10 + int'(bus.dig2),
                                               int'(bus.dig3) * 10 + int'(bus.dig4), bus.operation);

    function automatic logic [39:0] outs();
        return {bus.dig1, bus.dig2, bus.dig3, bus.dig4, bus.operation, bus.result_q, bus.neg_q,
                bus.busy, bus.done, bus.error, bus.show_result};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    // Steps cycles until done is seen; lat = 20 means it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- reference model ----------------
    int         m_phase, m_a, m_an, m_b, m_bn, m_op, m_rem;
    logic [13:0] m_res;
    logic        m_neg, m_done;

    task automatic model_step(input bit r, input bit v, input int c);
        m_done = 1'b0;
        if (r || (v && c == 15)) begin
            m_a = 0; m_an = 0; m_b = 0; m_bn = 0; m_op = 0; m_rem = 0;
            m_res = 14'd0; m_neg = 1'b0; m_phase = P_A;
        end else begin
            case (m_phase)
                P_A: if (v && c < 10) begin
                         if (m_an < 2) begin m_a = (m_a % 10) * 10 + c; m_an++; end
                     end else if (v && c >= 10 && c <= 13) begin
                         m_op = c - 10; m_phase = P_B;
                     end
                P_B: if (v && c < 10) begin
                         if (m_bn < 2) begin m_b = (m_b % 10) * 10 + c; m_bn++; end
                     end else if (v && c >= 10 && c <= 13) begin
                         if (m_bn == 0) m_op = c - 10;
                     end else if (v && c == 14) begin
                         if (m_op == 3 && m_b == 0) m_phase = P_ERR;
                         else begin m_phase = P_EXEC; m_rem = EXEC; end
                     end
                P_EXEC: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        {m_neg, m_res} = dp_eval(m_a, m_b, 5'(1 << m_op));
                        m_done = 1'b1;
                        m_phase = P_SHOW;
                    end
                end
                P_SHOW: if (v && c < 10) begin
                    m_a = c; m_an = 1; m_b = 0; m_bn = 0; m_phase = P_A;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [39:0] model_outs();
        logic [4:0] op;
        op = (m_phase == P_EXEC || m_phase == P_SHOW) ? 5'(1 << m_op) : 5'b10000;
        return {4'(m_a / 10), 4'(m_a % 10), 4'(m_b / 10), 4'(m_b % 10), op, m_res, m_neg,
                m_phase == P_EXEC, m_done, m_phase == P_ERR, m_phase == P_SHOW};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'd3;
        tick(); tick();
        tests_run++; if (outs() !== RST_OUTS) begin tests_failed++;
            $display("FAIL reset_vals got=%h want=%h", outs(), RST_OUTS); end
        @(negedge clk); reset = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;
        tick();
    endtask

    task automatic test_add();
        int lat;
        press(1); press(2); press(10); press(3); press(4);
        tests_run++; if ({bus.dig1, bus.dig2, bus.dig3, bus.dig4, bus.operation} !== {16'h1234, 5'b10000}) begin
            tests_failed++; $display("FAIL add_digits got=%h want=%h",
            {bus.dig1, bus.dig2, bus.dig3, bus.dig4, bus.operation}, {16'h1234, 5'b10000}); end
        press(14);
        tests_run++; if ({bus.operation, bus.busy, bus.done} !== {5'b00001, 2'b10}) begin tests_failed++;
            $display("FAIL add_exec got=%b want=%b", {bus.operation, bus.busy, bus.done}, {5'b00001, 2'b10}); end
        wait_done(lat);
        tests_run++; if (lat !== EXEC) begin tests_failed++;
            $display("FAIL add_latency got=%0d want=%0d", lat, EXEC); end
        tests_run++; if ({bus.result_q, bus.neg_q, bus.busy, bus.show_result} !== {14'd46, 3'b001}) begin
            tests_failed++; $display("FAIL add_result got=%0d/%b want=46/001", bus.result_q,
            {bus.neg_q, bus.busy, bus.show_result}); end
        tick();
        tests_run++; if ({bus.done, bus.show_result} !== 2'b01) begin tests_failed++;
            $display("FAIL add_done_pulse got=%b want=01", {bus.done, bus.show_result}); end
    endtask

    task automatic test_sub();
        int lat;
        press(15); press(0); press(5); press(11); press(1); press(7); press(14);
        tests_run++; if (bus.operation !== 5'b00010) begin tests_failed++;
            $display("FAIL sub_op got=%b want=00010", bus.operation); end
        wait_done(lat);
        tests_run++; if ({lat, bus.result_q, bus.neg_q, bus.show_result} !== {EXEC, 14'd12, 2'b11}) begin
            tests_failed++; $display("FAIL sub_result got=%0d/%0d/%b want=%0d/12/11", lat, bus.result_q,
            {bus.neg_q, bus.show_result}, EXEC); end
    endtask

    task automatic test_mul_then_digit();
        int lat;
        press(15); press(9); press(9); press(12); press(9); press(9); press(14);
        wait_done(lat);
        tests_run++; if ({bus.result_q, bus.neg_q} !== {14'd9801, 1'b0}) begin tests_failed++;
            $display("FAIL mul_result got=%0d want=9801", bus.result_q); end
        press(4);
        tests_run++; if ({bus.dig1, bus.dig2, bus.dig3, bus.dig4, bus.operation, bus.show_result}
                         !== {16'h0400, 5'b10000, 1'b0}) begin tests_failed++;
            $display("FAIL show_digit got=%h/%b want=0400/10000", {bus.dig1, bus.dig2, bus.dig3, bus.dig4},
            bus.operation); end
        press(10); press(3); press(14); wait_done(lat);
        tests_run++; if (bus.result_q !== 14'd7) begin tests_failed++;
            $display("FAIL show_restart got=%0d want=7", bus.result_q); end
    endtask

    task automatic test_div_zero();
        int lat;
        press(15); press(7); press(13); press(14);
        tests_run++; if ({bus.error, bus.busy, bus.show_result} !== 3'b100) begin tests_failed++;
            $display("FAIL div0_error got=%b want=100", {bus.error, bus.busy, bus.show_result}); end
        wait_done(lat);
        tests_run++; if ({lat, bus.busy, bus.error} !== {32'd20, 2'b01}) begin tests_failed++;
            $display("FAIL div0_no_done got=%0d/%b want=20/01", lat, {bus.busy, bus.error}); end
        press(5);
        tests_run++; if ({bus.dig2, bus.dig4, bus.error} !== {4'd7, 4'd0, 1'b1}) begin tests_failed++;
            $display("FAIL div0_ignore got=%h want=701", {bus.dig2, bus.dig4, bus.error}); end
        press(15);
        tests_run++; if (outs() !== RST_OUTS) begin tests_failed++;
            $display("FAIL div0_clear got=%h want=%h", outs(), RST_OUTS); end
    endtask

    task automatic test_op_replace();
        int lat;
        press(1); press(2); press(3);
        tests_run++; if ({bus.dig1, bus.dig2} !== 8'h12) begin tests_failed++;
            $display("FAIL a_full got=%h want=12", {bus.dig1, bus.dig2}); end
        press(10); press(12); press(5); press(11); press(14);
        tests_run++; if (bus.operation !== 5'b00100) begin tests_failed++;
            $display("FAIL op_replace got=%b want=00100", bus.operation); end
        wait_done(lat);
        tests_run++; if (bus.result_q !== 14'd60) begin tests_failed++;
            $display("FAIL op_replace_result got=%0d want=60", bus.result_q); end
    endtask

    task automatic test_clear_mid_exec();
        int lat;
        press(15); press(4); press(10); press(4); press(14); tick(); press(15);
        tests_run++; if (outs() !== RST_OUTS) begin tests_failed++;
            $display("FAIL exec_abort got=%h want=%h", outs(), RST_OUTS); end
        wait_done(lat);
        tests_run++; if ({lat, outs()} !== {32'd20, RST_OUTS}) begin tests_failed++;
            $display("FAIL exec_abort_quiet got=%0d/%h want=20/%h", lat, outs(), RST_OUTS); end
    endtask

    task automatic test_reset_in_show();
        int lat;
        press(4); press(10); press(4); press(14); wait_done(lat);
        tests_run++; if ({bus.show_result, bus.result_q} !== {1'b1, 14'd8}) begin tests_failed++;
            $display("FAIL show_before_reset got=%b/%0d want=1/8", bus.show_result, bus.result_q); end
        @(negedge clk); reset = 1'b1; tick(); @(negedge clk); reset = 1'b0;
        tests_run++; if (outs() !== RST_OUTS) begin tests_failed++;
            $display("FAIL reset_in_show got=%h want=%h", outs(), RST_OUTS); end
    endtask

    task automatic test_random();
        bit r, v;
        int c, x;
        @(negedge clk); reset = 1'b1; tick();
        model_step(1'b1, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 7);
            x = $urandom_range(0, 99);
            if (x < 55)      c = $urandom_range(0, 9);
            else if (x < 75) c = 10 + $urandom_range(0, 3);
            else if (x < 96) c = 14;
            else             c = 15;
            reset = r; bus.key_valid = v; bus.key_code = 4'(c);
            tick();
            model_step(r, v, c);
            tests_run++; if (outs() !== model_outs()) begin tests_failed++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, outs(), model_outs()); end
        end
        @(negedge clk); reset = 1'b0; bus.key_valid = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        reset = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_mul_then_digit();
        test_div_zero();
        test_op_replace();
        test_clear_mid_exec();
        test_reset_in_show();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Keypad-driven controller that sequences the calculator's two-operand arithmetic datapath (add, subtract, multiply, divide on two 2-digit BCD operands). It assembles operand digits from single-cycle key events and drives the datapath's one-hot operation select. It waits the datapath's fixed latency, then captures the result for display. It sits between the keypad decoder and the arithmetic block, and owns the `dig1..dig4` and `operation` inputs of that block.

## Interface
- `EXEC_CYCLES`, default 3: clock edges from acceptance of `=` to result capture. Legal range is 2..15.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  single-cycle strobe; `key_code` is valid when this is high.
- `key_code`  in  4  codes: 0–9 digit, 10 `+`, 11 `−`, 12 `×`, 13 `÷`, 14 `=`, 15 clear.
- `result_in`  in  14  datapath result magnitude.
- `neg_in`  in  1  datapath negative flag.
- `dig1, dig2`  out  4 each  operand A tens, units (BCD 0–9).
- `dig3, dig4`  out  4 each  operand B tens, units.
- `operation`  out  5  one-hot to datapath: [0] add, [1] sub, [2] mul, [3] div, [4] show operands.
- `result_q`  out  14  captured result.
- `neg_q`  out  1  captured sign.
- `busy`  out  1  high in EXEC.
- `done`  out  1  one-cycle pulse on result capture.
- `error`  out  1  high in ERR (divide by zero).
- `show_result`  out  1  high in SHOW; display mux selects `result_q`.

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW, ERR. The state is ENTER_A after reset.
- Registers: operand digits; `a_cnt`, `b_cnt` (digits entered, 0–2); `op_sel` (one-hot, 4 bits); exec counter (4 bits).
- Digit entry into the current operand: if count < 2, shift left (tens ← units, units ← key), then count++. If count = 2, the key is ignored.
- ENTER_A:
  - digit → enter into A.
  - operator key → latch `op_sel`, go to ENTER_B. A with zero digits is 00.
  - `=` → ignored.
- ENTER_B:
  - digit → enter into B.
  - operator key with `b_cnt` = 0 → replaces `op_sel`. With `b_cnt` > 0 it is ignored.
  - `=` with `op_sel` = div and B = 00 → ERR.
  - `=` otherwise → EXEC, load counter with EXEC_CYCLES−1.
- EXEC: all non-clear keys are ignored. Counter decrements each cycle. At counter = 0: `result_q` ← `result_in`, `neg_q` ← `neg_in`, `done` = 1 for that cycle, then go to SHOW.
- SHOW:
  - digit → clear all digits and counts, enter the digit as A units, go to ENTER_A.
  - operator or `=` → ignored.
- ERR: only clear is accepted.
- Clear (15), in any state: zero all digits, counts, `op_sel`, `result_q`, `neg_q`, and the counter; go to ENTER_A. Clear has priority over everything except `reset`.
- `operation` output: `op_sel` in EXEC and SHOW; 5'b10000 in all other states. Exactly one bit is ever set.
- Digits are never outside 0–9. `key_code` values 10–15 never write a digit register.

## Timing
- All outputs are registered. Reset values: digits 0, `operation` = 5'b10000, `result_q` = 0, `neg_q` = 0, `busy` = 0, `done` = 0, `error` = 0, `show_result` = 0.
- A key accepted at edge N is visible on the outputs after edge N.
- `=` is accepted at edge E:
  - `operation` switches to `op_sel` and `busy` rises after E.
  - Capture happens at edge E+EXEC_CYCLES; `done` is high for the cycle after it.
  - `busy` falls and `show_result` rises at the same edge as capture.
- The datapath needs 2 edges after `operation` changes with stable digits. EXEC_CYCLES ≥ 2 guarantees a valid capture.
- A `reset` that coincides with `key_valid` wins.
- A clear during EXEC aborts the operation: no `done` is issued and `result_q` stays 0.
- `key_valid` held high for multiple cycles counts as one key per cycle. Debouncing and edge detection are upstream.

## Test plan
- Keys 1, 2, `+`, 3, 4, `=` → digits 1, 2, 3, 4. `operation` = 00001 during EXEC. `done` 3 edges after `=`. `result_q` = 46, `neg_q` = 0.
- Keys 0, 5, `−`, 1, 7, `=` → `operation` = 00010. `result_q` = 12, `neg_q` = 1. `show_result` = 1.
- Keys 9, 9, `×`, 9, 9, `=` → `result_q` = 9801. A following digit 4 leaves `dig1`/`dig2` = 0/4 and returns the state to ENTER_A.
- Keys 7, `÷`, `=` → `error` = 1, `busy` never set, no `done`. Further digits are ignored. Clear → `error` = 0, `operation` = 10000.
- Keys 1, 2, 3 → A = 12, third key ignored. Then `+`, `×`, 5, `−`, `=` → `op_sel` = mul (`−` is ignored once B has a digit), `operation` = 00100, `result_q` = 60.
- Keys 4, `+`, 4, `=`, then clear one cycle later, mid-EXEC → no `done`, all outputs at reset values. `reset` asserted in SHOW gives the same result.
